// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_if.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_if.sv - control bundle of the programmable clock divider
// The controller drives EN/DIV/LD; the divider returns ACK/RUNNING.
interface gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_if #(
  parameter int W = 4
);
  logic         EN;
  logic [W-1:0] DIV;
  logic         LD;
  logic         ACK;
  logic         RUNNING;

  modport master (
    output EN,
    output DIV,
    output LD,
    input  ACK,
    input  RUNNING
  );

  modport slave (
    input  EN,
    input  DIV,
    input  LD,
    output ACK,
    output RUNNING
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv - glitch-free programmable integer clock divider
// Ratio N = act_div + 2; ratio and run/stop changes only take effect at period boundaries.
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog #(
  parameter int          W       = 4,
  parameter logic [W-1:0] RST_DIV = '0
) (
  input  logic                                         CLK,
  input  logic                                         RN,
  gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_if.slave        ctl,
  output logic                                         CLKO
);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t       state_q,   state_d;
  logic [W:0]   cnt_q,     cnt_d;
  logic [W-1:0] act_div_q, act_div_d;
  logic [W-1:0] shd_div_q, shd_div_d;
  logic         pend_q,    pend_d;
  logic         clko_q,    clko_d;
  logic         ack_q,     ack_d;
  logic         running_q, running_d;

  logic [W:0]   n_cur;
  logic [W:0]   h_cur;
  logic [W:0]   cnt_inc;
  logic         boundary;
  logic         apply_req;
  logic [W-1:0] apply_div;

  // An LD on the applying edge wins over the older shadow value.
  assign apply_req = pend_q | ctl.LD;
  assign apply_div = ctl.LD ? ctl.DIV : shd_div_q;

  assign n_cur    = {1'b0, act_div_q} + (W+1)'(2);
  assign h_cur    = n_cur >> 1;
  assign cnt_inc  = cnt_q + (W+1)'(1);
  assign boundary = (cnt_q == (n_cur - (W+1)'(1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_div_d = act_div_q;
    shd_div_d = shd_div_q;
    pend_d    = pend_q;
    clko_d    = clko_q;
    ack_d     = 1'b0;

    if (ctl.LD) begin
      shd_div_d = ctl.DIV;
      pend_d    = 1'b1;
    end

    unique case (state_q)
      ST_STOP: begin
        cnt_d  = '0;
        clko_d = 1'b0;
        if (apply_req) begin
          act_div_d = apply_div;
          pend_d    = 1'b0;
          ack_d     = 1'b1;
        end
        if (ctl.EN) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          clko_d  = 1'b1;
        end
      end

      ST_RUN: begin
        if (!boundary) begin
          cnt_d  = cnt_inc;
          clko_d = (cnt_inc < h_cur);
        end else begin
          // The period has completed; a new ratio governs the next one.
          if (apply_req) begin
            act_div_d = apply_div;
            pend_d    = 1'b0;
            ack_d     = 1'b1;
          end
          cnt_d = '0;
          if (ctl.EN) begin
            clko_d = 1'b1;
          end else begin
            state_d = ST_STOP;
            clko_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
        clko_d  = 1'b0;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_STOP;
      cnt_q     <= '0;
      act_div_q <= RST_DIV;
      shd_div_q <= RST_DIV;
      pend_q    <= 1'b0;
      clko_q    <= 1'b0;
      ack_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      shd_div_q <= shd_div_d;
      pend_q    <= pend_d;
      clko_q    <= clko_d;
      ack_q     <= ack_d;
      running_q <= running_d;
    end
  end

  assign CLKO        = clko_q;
  assign ctl.ACK     = ack_q;
  assign ctl.RUNNING = running_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.md
Name: gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog

Overview:
- Programmable, glitch-free integer clock divider. It sits directly upstream of the clkbuf_16 clock-tree root buffer.
- Its registered output CLKO drives the buffer input, so the buffer fans out a divided, start/stop-controlled clock.
- The divide ratio can change at run time. Every change takes effect only at a period boundary, so CLKO never produces a runt pulse.

Parameters:
- W, 4: width of DIV. Ratio N = DIV + 2, so N ranges 2 .. 2^W+1.
- RST_DIV, 0: active DIV value loaded at reset (reset ratio = RST_DIV + 2).

Ports:
- CLK  input  1  source clock, rising-edge.
- RN  input  1  reset; asynchronous, active-low.
- EN  input  1  run request; sampled only at period boundaries and in STOP.
- DIV  input  W  requested ratio code; captured when LD = 1.
- LD  input  1  load strobe for DIV.
- CLKO  output  1  divided clock; registered; feeds the clock buffer.
- ACK  output  1  one-cycle pulse on the cycle the new ratio becomes active.
- RUNNING  output  1  1 while in RUN state.

Behaviour:
- State and registers:
  - State register: STOP or RUN.
  - cnt: W+1 bits.
  - act_div: active ratio code, W bits.
  - shd_div: shadow ratio code, W bits.
  - pend: 1 bit.
  - Let N = act_div + 2 and H = floor(N/2).
- Reset (RN = 0, asynchronous): STOP, cnt = 0, CLKO = 0, ACK = 0, RUNNING = 0, act_div = RST_DIV, pend = 0. The outputs go low immediately, without waiting for a CLK edge.
- All state updates on the rising CLK edge. ACK defaults to 0 on every edge unless set below.
- Shadow load: LD = 1 at an edge sets shd_div = DIV and pend = 1. A newer LD overwrites any pending value; only the last one is applied.
- STOP state:
  - CLKO = 0, cnt = 0.
  - If pend = 1: act_div <= shd_div, pend <= 0, ACK <= 1. This applies on the edge after LD (and on the same edge if LD is also 1 there). When LD is present on that edge, the DIV value on LD is used.
  - If EN = 1: next state RUN, cnt <= 0, CLKO <= 1. CLKO rises 1 cycle after EN is sampled high. When pend and EN are applied on the same edge, the new ratio governs that first period.
- RUN state, cnt < N-1:
  - cnt <= cnt + 1.
  - CLKO <= ((cnt+1) < H).
  - The high phase lasts H cycles and the low phase N-H cycles. Odd N gives the extra cycle to the low phase.
- RUN state, period boundary (cnt = N-1):
  - If pend: apply the shadow (act_div update, ACK pulse, pend clear). The new N governs the next period.
  - If EN = 1: cnt <= 0, CLKO <= 1 (the new period starts).
  - If EN = 0: go to STOP, CLKO <= 0.
  - A period in progress always completes, so the final low phase is never truncated.
- EN deassertion mid-period has no effect until the boundary. EN toggling between boundaries is ignored.
- LD on the boundary edge itself: the newly captured DIV is applied on that same edge, with ACK = 1.
- RUNNING = (state == RUN), registered.
- CLKO is driven directly from a flop; no combinational logic follows it.

Test Plan:
- Reset check: RN = 0 mid-high phase with DIV = 3 running -> CLKO = 0, RUNNING = 0, ACK = 0 immediately; after RN = 1 with EN = 0, CLKO stays 0.
- N = 2 (RST_DIV = 0), EN = 1 from reset release -> CLKO rises 1 cycle later, then 1,0,1,0... with period 2 CLK cycles; RUNNING = 1.
- Odd ratio: in STOP, LD = 1 with DIV = 3 -> ACK pulses on the next edge; then EN = 1 -> CLKO high 2 cycles, low 3 cycles, period 5, repeating.
- Runtime change: running with N = 5, LD with DIV = 6 at cnt = 1, then LD with DIV = 2 at cnt = 3 -> current period finishes as 2H/3L; exactly one ACK at the boundary; the next period is N = 4 (2H/2L).
- Graceful stop: N = 6, EN drops at cnt = 1 -> CLKO completes 3 high + 3 low, then stays 0; RUNNING falls at the boundary; EN re-asserted -> CLKO high 1 cycle after EN is sampled.
- Boundary coincidence: LD with DIV = 0 exactly at cnt = N-1 while EN = 1 -> ACK on that edge; the immediately following period is 1H/1L.
